// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//   Shares a single UART TX serializer between N_REQ byte-stream clients.
//   Ownership is granted round-robin. An owner keeps the transmitter until
//   it sends a byte flagged last, drops its request, hits MAX_BYTES bytes
//   in one grant, or the serializer fails to answer a start pulse.
//
// Ports
//   clk       system clock
//   rst       synchronous active-high reset
//   req       per-client byte-valid
//   req_data  per-client byte, client i at [8*i+7:8*i]
//   req_last  per-client end-of-message flag
//   ack       one-cycle pulse: client's byte was taken
//   grant     one-hot current owner, zero when idle
//   tx_start  one-cycle load strobe to the serializer
//   tx_data   byte for the serializer, valid with tx_start
//   tx_busy   serializer busy
//   fault     sticky: serializer never raised tx_busy after a start
module uart_tx_arbiter #(
   parameter int N_REQ     = 4,
   parameter int MAX_BYTES = 16,
   parameter int BUSY_WAIT = 15
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [N_REQ-1:0]   req,
   input  logic [8*N_REQ-1:0] req_data,
   input  logic [N_REQ-1:0]   req_last,
   output logic [N_REQ-1:0]   ack,
   output logic [N_REQ-1:0]   grant,
   output logic               tx_start,
   output logic [7:0]         tx_data,
   input  logic               tx_busy,
   output logic               fault
);

   localparam int IDX_W  = $clog2(N_REQ);
   localparam int CNT_W  = $clog2(MAX_BYTES + 1);
   localparam int WAIT_W = $clog2(BUSY_WAIT + 1);

   localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(N_REQ - 1);
   localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(MAX_BYTES);
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(BUSY_WAIT - 1);

   typedef enum logic [2:0] {
      IDLE,
      ARB,
      LOAD,
      WBUSY,
      WDONE
   } state_t;

   state_t            state;
   logic [IDX_W-1:0]  ptr;
   logic [IDX_W-1:0]  owner;
   logic [CNT_W-1:0]  byte_cnt;
   logic [WAIT_W-1:0] wait_cnt;
   logic              last_flag;

   logic [7:0]        data_arr [N_REQ];
   logic [IDX_W-1:0]  pick_idx;
   logic [IDX_W-1:0]  sel_idx;
   logic              sel_req;
   logic              sel_last;
   logic [7:0]        sel_data;
   logic              msg_done;
   logic              issue;
   logic              release_now;

   // (base + off) mod N_REQ for off in 0..N_REQ-1
   function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] base, input int off);
      int s;
      s = int'(base) + off;
      if (s >= N_REQ) s = s - N_REQ;
      return IDX_W'(s);
   endfunction

   always_comb begin
      for (int i = 0; i < N_REQ; i++) data_arr[i] = req_data[8*i +: 8];
   end

   // Round-robin search: scan from the farthest offset down to ptr so the
   // requester closest to ptr (in wrap order) is the one left standing.
   always_comb begin
      // NOTE: every variable gets a default before any conditional write, so no latch is inferred.
      pick_idx = ptr;
      for (int k = N_REQ - 1; k >= 0; k--) begin
         if (req[wrap_add(ptr, k)]) pick_idx = wrap_add(ptr, k);
      end
   end

   // In ARB the candidate is the freshly picked client, otherwise the owner.
   always_comb begin
      sel_idx  = (state == ARB) ? pick_idx : owner;
      sel_req  = req[sel_idx];
      sel_last = req_last[sel_idx];
      sel_data = data_arr[sel_idx];
      msg_done = last_flag || (byte_cnt == CNT_MAX);

      // A byte is launched on the edge that enters LOAD, so tx_start/ack are
      // high during the LOAD cycle itself (IDLE -> ARB -> LOAD = 2 cycles).
      // ARB holds off while the serializer is still shifting a byte that
      // survived a reset.
      issue = ((state == ARB)   && (|req) && !tx_busy) ||
              ((state == WDONE) && !tx_busy && !msg_done && sel_req);

      // LOAD without a launched byte means the owner dropped its request.
      release_now = ((state == LOAD)  && !tx_start) ||
                    ((state == WBUSY) && !tx_busy && (wait_cnt == WAIT_LAST)) ||
                    ((state == WDONE) && !tx_busy && msg_done);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         grant     <= '0;
         ack       <= '0;
         tx_start  <= 1'b0;
         tx_data   <= 8'h00;
         fault     <= 1'b0;
         ptr       <= '0;
         owner     <= '0;
         byte_cnt  <= '0;
         wait_cnt  <= '0;
         last_flag <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments throughout; a later assignment in this
         // block overrides an earlier one, which is how pulses default low and
         // how a release overrides the per-state next-state choice.
         tx_start <= 1'b0;
         ack      <= '0;

         case (state)
            IDLE: begin
               if (|req) state <= ARB;
            end
            ARB: begin
               if (!(|req)) begin
                  state <= IDLE;
               end else if (!tx_busy) begin
                  state <= LOAD;
                  owner <= pick_idx;
                  grant <= N_REQ'(1) << pick_idx;
               end
            end
            LOAD: begin
               state    <= WBUSY;
               wait_cnt <= '0;
            end
            WBUSY: begin
               // tx_busy already high on entry advances immediately.
               if (tx_busy)                     state    <= WDONE;
               else if (wait_cnt == WAIT_LAST)  fault    <= 1'b1;
               else                             wait_cnt <= wait_cnt + WAIT_W'(1);
            end
            WDONE: begin
               if (!tx_busy && !msg_done) state <= LOAD;
            end
            default: state <= IDLE;
         endcase

         if (issue) begin
            tx_start  <= 1'b1;
            tx_data   <= sel_data;
            ack       <= N_REQ'(1) << sel_idx;
            last_flag <= sel_last;
            byte_cnt  <= (state == ARB) ? CNT_W'(1) : byte_cnt + CNT_W'(1);
         end

         // Pointer moves only on release so a streaming owner still yields.
         if (release_now) begin
            state <= IDLE;
            grant <= '0;
            ptr   <= (owner == IDX_LAST) ? '0 : owner + IDX_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter
//   Self-checking bench for uart_tx_arbiter (N_REQ=4, MAX_BYTES=4, BUSY_WAIT=15).
//   A behavioural serializer answers tx_start with tx_busy; queue-based clients
//   feed message streams; a transaction-level scheduler predicts byte order.
module tb_uart_tx_arbiter;

   localparam int N    = 4;
   localparam int MAXB = 4;
   localparam int BW   = 15;

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic [N-1:0]   req = '0;
   logic [8*N-1:0] req_data = '0;
   logic [N-1:0]   req_last = '0;
   logic [N-1:0]   ack;
   logic [N-1:0]   grant;
   logic           tx_start;
   logic [7:0]     tx_data;
   logic           tx_busy = 1'b0;
   logic           fault;

   uart_tx_arbiter #(.N_REQ(N), .MAX_BYTES(MAXB), .BUSY_WAIT(BW)) dut (
      .clk      (clk),
      .rst      (rst),
      .req      (req),
      .req_data (req_data),
      .req_last (req_last),
      .ack      (ack),
      .grant    (grant),
      .tx_start (tx_start),
      .tx_data  (tx_data),
      .tx_busy  (tx_busy),
      .fault    (fault)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 'h%0h, expected 'h%0h", name, got, exp);
      end
   endtask

   // Directed drive values, copied onto the DUT inputs when clients are off.
   logic [N-1:0]   dir_req  = '0;
   logic [8*N-1:0] dir_data = '0;
   logic [N-1:0]   dir_last = '0;

   bit client_on = 1'b0;
   bit stream_on = 1'b0;
   bit ser_dead  = 1'b0;
   int ser_hold_fix = 0;
   int ser_rise = 0;
   int ser_hold = 0;
   int n_starts = 0;

   logic [8:0] cq [N][$];   // per client: {last, byte}
   logic [8:0] mq [N][$];   // model scratch copy
   logic [9:0] exq [$];     // expected {owner, byte}

   function automatic int oh_idx(input logic [N-1:0] v);
      int r;
      r = -1;
      for (int i = 0; i < N; i++) if (v[i]) r = i;
      return r;
   endfunction

   // Monitor, serializer model and clients, all at the falling edge.
   always @(negedge clk) begin : neg_proc
      logic [9:0] e;
      logic [8:0] tmp;
      if (tx_start || (ack != '0)) begin
         check("ack_with_start", 32'(ack != '0), 32'(tx_start));
         check("ack_in_grant", 32'(ack & ~grant), 32'(0));
      end
      if (tx_start) begin
         n_starts++;
         check("start_while_busy", 32'(tx_busy), 32'(0));
         check("grant_onehot", 32'($countones(grant)), 32'(1));
         if (stream_on) begin
            if (exq.size() == 0) begin
               check("stream_unexpected_start", 32'(exq.size()), 32'(1));
            end else begin
               e = exq.pop_front();
               check("stream_owner", 32'(oh_idx(grant)), 32'(e[9:8]));
               check("stream_byte", 32'(tx_data), 32'(e[7:0]));
            end
         end
      end

      // serializer: busy rises ser_rise cycles after tx_start, stays ser_hold cycles
      if (ser_rise > 0) begin
         ser_rise--;
         if (ser_rise == 0) begin
            tx_busy  = 1'b1;
            ser_hold = (ser_hold_fix > 0) ? ser_hold_fix : int'($urandom_range(6, 1));
         end
      end else if (ser_hold > 0) begin
         ser_hold--;
         if (ser_hold == 0) tx_busy = 1'b0;
      end
      if (tx_start && !ser_dead) ser_rise = int'($urandom_range(6, 1));

      if (client_on) begin
         for (int i = 0; i < N; i++) begin
            if (ack[i] && cq[i].size() > 0) tmp = cq[i].pop_front();
            req[i] = (cq[i].size() > 0);
            if (cq[i].size() > 0) begin
               tmp = cq[i][0];
               req_data[8*i +: 8] = tmp[7:0];
               req_last[i]        = tmp[8];
            end
         end
      end else begin
         req      = dir_req;
         req_data = dir_data;
         req_last = dir_last;
      end
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      dir_req = '0;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic wait_start(input string name, input int budget);
      int t;
      t = 0;
      while (!tx_start && t < budget) begin tick(); t++; end
      check({name, "_start_seen"}, 32'(tx_start), 32'(1));
   endtask

   task automatic wait_release(input string name, input int budget);
      int t;
      t = 0;
      while (grant != '0 && t < budget) begin tick(); t++; end
      check({name, "_released"}, 32'(grant), 32'(0));
      check({name, "_busy_low_at_release"}, 32'(tx_busy), 32'(0));
   endtask

   // Scheduler model: round-robin over non-empty client queues, an owner
   // sends until a last byte, MAXB bytes, or its queue runs dry.
   task automatic build_expected();
      int p, g, cnt;
      logic [8:0] b;
      for (int i = 0; i < N; i++) mq[i] = cq[i];
      p = 0;
      while (1) begin
         g = -1;
         for (int k = 0; k < N; k++) if (g < 0 && mq[(p + k) % N].size() > 0) g = (p + k) % N;
         if (g < 0) break;
         cnt = 0;
         do begin
            b = mq[g].pop_front();
            exq.push_back({2'(g), b[7:0]});
            cnt++;
         end while (!b[8] && cnt < MAXB && mq[g].size() > 0);
         p = (g + 1) % N;
      end
   endtask

   task automatic run_stream(input string name, input int budget);
      int t;
      t = 0;
      stream_on = 1'b1;
      client_on = 1'b1;
      tick();
      while (!(exq.size() == 0 && grant == '0 && req == '0) && t < budget) begin tick(); t++; end
      check({name, "_in_budget"}, 32'(t < budget), 32'(1));
      check({name, "_expected_left"}, 32'(exq.size()), 32'(0));
      for (int i = 0; i < N; i++) check({name, "_client_left"}, 32'(cq[i].size()), 32'(0));
      stream_on = 1'b0;
      client_on = 1'b0;
      dir_req   = '0;
      exq.delete();
      for (int i = 0; i < N; i++) cq[i].delete();
   endtask

   typedef struct {
      logic [N-1:0]   req;
      logic [8*N-1:0] data;
      logic [N-1:0]   exp_grant;
      logic [7:0]     exp_data;
   } vec_t;

   vec_t tbl [10];

   initial begin
      int nmsg, len;

      tbl[0] = '{4'b1011, 32'h3322_1100, 4'b0001, 8'h00};
      tbl[1] = '{4'b1011, 32'h3726_1504, 4'b0010, 8'h15};
      tbl[2] = '{4'b1011, 32'h3b2a_1908, 4'b1000, 8'h3b};
      tbl[3] = '{4'b1011, 32'h4f3e_2d1c, 4'b0001, 8'h1c};
      tbl[4] = '{4'b0010, 32'h0000_4100, 4'b0010, 8'h41};
      tbl[5] = '{4'b0001, 32'h0000_005a, 4'b0001, 8'h5a};
      tbl[6] = '{4'b1100, 32'hc396_0000, 4'b0100, 8'h96};
      tbl[7] = '{4'b1111, 32'hf0e1_d2c3, 4'b1000, 8'hf0};
      tbl[8] = '{4'b1110, 32'h8877_a655, 4'b0010, 8'ha6};
      tbl[9] = '{4'b1001, 32'h6d00_004b, 4'b1000, 8'h6d};

      // reset state
      do_reset();
      check("rst_grant", 32'(grant), 32'(0));
      check("rst_ack", 32'(ack), 32'(0));
      check("rst_tx_start", 32'(tx_start), 32'(0));
      check("rst_tx_data", 32'(tx_data), 32'(0));
      check("rst_fault", 32'(fault), 32'(0));

      // single-byte messages from idle: latency, round-robin order, data mux
      for (int v = 0; v < 10; v++) begin
         dir_data = tbl[v].data;
         dir_last = '1;
         dir_req  = tbl[v].req;
         tick();
         check("vec_arb_no_start", 32'(tx_start), 32'(0));
         check("vec_arb_no_grant", 32'(grant), 32'(0));
         tick();
         check("vec_tx_start", 32'(tx_start), 32'(1));
         check("vec_tx_data", 32'(tx_data), 32'(tbl[v].exp_data));
         check("vec_grant", 32'(grant), 32'(tbl[v].exp_grant));
         check("vec_ack", 32'(ack), 32'(tbl[v].exp_grant));
         dir_req = '0;
         wait_release("vec", 60);
      end

      // message lock: client 0 sends 3 bytes while client 2 waits
      cq[0] = '{9'h00a, 9'h00b, 9'h10c};
      cq[2] = '{9'h12c};
      exq   = '{10'h00a, 10'h00b, 10'h00c, 10'h22c};
      run_stream("lock", 400);

      // MAX_BYTES cut: client 3 streams 6 bytes, client 0 waiting
      cq[3] = '{9'h030, 9'h031, 9'h032, 9'h033, 9'h034, 9'h135};
      cq[0] = '{9'h1a0};
      exq   = '{10'h330, 10'h331, 10'h332, 10'h333, 10'h0a0, 10'h334, 10'h335};
      run_stream("maxcut", 800);

      // fault: serializer never answers
      ser_dead = 1'b1;
      dir_data = 32'h0000_5e00;
      dir_last = '1;
      dir_req  = 4'b0010;
      wait_start("fault", 10);
      check("fault_grant", 32'(grant), 32'(4'b0010));
      dir_req = '0;
      repeat (BW) tick();
      check("fault_not_early", 32'(fault), 32'(0));
      check("fault_still_granted", 32'(grant), 32'(4'b0010));
      tick();
      check("fault_set", 32'(fault), 32'(1));
      check("fault_released", 32'(grant), 32'(0));
      ser_dead = 1'b0;
      dir_data = 32'h0077_0000;
      dir_req  = 4'b0100;
      tick();
      tick();
      check("after_fault_start", 32'(tx_start), 32'(1));
      check("after_fault_data", 32'(tx_data), 32'(8'h77));
      check("after_fault_grant", 32'(grant), 32'(4'b0100));
      check("fault_sticky", 32'(fault), 32'(1));
      dir_req = '0;
      wait_release("after_fault", 60);

      // reset during WDONE of byte 2 of 3
      begin
         int base, t;
         ser_hold_fix = 10;
         cq[1] = '{9'h0b0, 9'h0b1, 9'h1b2};
         base = n_starts;
         client_on = 1'b1;
         t = 0;
         while (n_starts < base + 2 && t < 200) begin tick(); t++; end
         check("rstmid_two_bytes", 32'(n_starts - base), 32'(2));
         t = 0;
         while (!tx_busy && t < 50) begin tick(); t++; end
         check("rstmid_in_wdone", 32'(tx_busy), 32'(1));
         rst = 1'b1;
         client_on = 1'b0;
         dir_req = '0;
         cq[1].delete();
         tick();
         rst = 1'b0;
         check("rstmid_grant", 32'(grant), 32'(0));
         check("rstmid_ack", 32'(ack), 32'(0));
         check("rstmid_tx_start", 32'(tx_start), 32'(0));
         check("rstmid_fault_cleared", 32'(fault), 32'(0));
         dir_data = 32'h9900_0000;
         dir_last = '1;
         dir_req  = 4'b1000;
         wait_start("rstmid_new", 40);
         check("rstmid_new_data", 32'(tx_data), 32'(8'h99));
         check("rstmid_new_grant", 32'(grant), 32'(4'b1000));
         dir_req = '0;
         wait_release("rstmid", 60);
         ser_hold_fix = 0;
      end

      // randomized message streams against the scheduler model
      for (int r = 0; r < 4; r++) begin
         do_reset();
         for (int i = 0; i < N; i++) begin
            nmsg = int'($urandom_range(2, 0));
            for (int m = 0; m < nmsg; m++) begin
               len = int'($urandom_range(6, 1));
               for (int b = 0; b < len; b++) cq[i].push_back({b == len - 1, 8'($urandom)});
            end
         end
         build_expected();
         run_stream("rnd", 3000);
         check("rnd_no_fault", 32'(fault), 32'(0));
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
